// File: rtl/snes_pad_scanner.sv
// Multi-pad SNES controller scanner: drives a shared latch/clock pair,
// deserialises each pad's serial line and commits buttons, presence and
// one-cycle pressed edges at the end of every scan.
module snes_pad_scanner #(
  parameter int PADS         = 2,
  parameter int BITS         = 16,
  parameter int LATCH_CYCLES = 600,
  parameter int HALF_CYCLES  = 300,
  parameter int POLL_CYCLES  = 833333
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 auto_poll,
  input  logic                 start,
  input  logic [PADS-1:0]      serial_data,
  output logic                 data_latch,
  output logic                 data_clock,
  output logic [PADS*BITS-1:0] buttons,
  output logic [PADS-1:0]      present,
  output logic [PADS*BITS-1:0] pressed_edge,
  output logic                 update,
  output logic                 busy
);

  localparam int CNT_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam int POLL_W  = (POLL_CYCLES > 2) ? $clog2(POLL_CYCLES) : 1;
  localparam int K_W     = $clog2(BITS);

  typedef enum logic [2:0] {IDLE, LATCH, SHIFT_LO, SHIFT_HI, DONE} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [K_W-1:0]     bit_reg, bit_next;
  logic [POLL_W-1:0]  poll_reg;
  logic [PADS-1:0]    sync1_reg, sync2_reg;
  logic               data_latch_reg, data_clock_reg, busy_reg, update_reg;
  logic               scan_start, sample_en, commit;

  // Next-state logic: phase timing, bit index and the sample/commit strobes.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    scan_start = 1'b0;
    sample_en  = 1'b0;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start || (auto_poll && poll_reg == '0)) begin
          scan_start = 1'b1;
          state_next = LATCH;
          cnt_next   = '0;
        end
      end
      LATCH: begin
        if (cnt_reg == CNT_W'(LATCH_CYCLES - 1)) begin
          state_next = SHIFT_LO;
          cnt_next   = '0;
          bit_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      SHIFT_LO: begin
        if (cnt_reg == CNT_W'(HALF_CYCLES - 1)) begin
          sample_en  = 1'b1;
          state_next = SHIFT_HI;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      SHIFT_HI: begin
        if (cnt_reg == CNT_W'(HALF_CYCLES - 1)) begin
          cnt_next = '0;
          if (bit_reg == K_W'(BITS - 1)) begin
            state_next = DONE;
            commit     = 1'b1;
          end else begin
            bit_next   = bit_reg + 1'b1;
            state_next = SHIFT_LO;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, counters and the registered pad-facing strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      bit_reg        <= '0;
      data_latch_reg <= 1'b0;
      data_clock_reg <= 1'b1;
      busy_reg       <= 1'b0;
      update_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      bit_reg        <= bit_next;
      data_latch_reg <= (state_next == LATCH);
      data_clock_reg <= (state_next != SHIFT_LO);
      busy_reg       <= (state_next != IDLE);
      update_reg     <= commit;
    end
  end

  // Free-running poll counter: reloads at scan start, saturates at zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      poll_reg <= '0;
    else if (scan_start)
      poll_reg <= POLL_W'(POLL_CYCLES - 1);
    else if (poll_reg != '0)
      poll_reg <= poll_reg - 1'b1;
  end

  // Two-flop synchroniser on the asynchronous pad data lines.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_reg <= '1;
      sync2_reg <= '1;
    end else begin
      sync1_reg <= serial_data;
      sync2_reg <= sync1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PADS; gi++) begin : g_pad
      logic [BITS-1:0] shadow_reg, btn_reg, edge_reg, btn_next;
      logic            present_reg, absent;

      // A pad with nothing plugged in reads all ones in its top four bits.
      assign absent   = &shadow_reg[BITS-1:BITS-4];
      assign btn_next = absent ? {BITS{1'b1}} : shadow_reg;

      // Per-pad shift capture and end-of-scan commit.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          shadow_reg  <= '1;
          btn_reg     <= '1;
          edge_reg    <= '0;
          present_reg <= 1'b0;
        end else begin
          if (sample_en)
            shadow_reg[bit_reg] <= sync2_reg[gi];
          if (commit) begin
            btn_reg     <= btn_next;
            edge_reg    <= btn_reg & ~btn_next;
            present_reg <= ~absent;
          end else begin
            edge_reg <= '0;
          end
        end
      end

      assign buttons[gi*BITS +: BITS]      = btn_reg;
      assign pressed_edge[gi*BITS +: BITS] = edge_reg;
      assign present[gi]                   = present_reg;
    end
  endgenerate

  assign data_latch = data_latch_reg;
  assign data_clock = data_clock_reg;
  assign busy       = busy_reg;
  assign update     = update_reg;

endmodule

// File: tb/tb_snes_pad_scanner.sv
// Bench for snes_pad_scanner: behavioural pad shift registers, table-driven
// manual scans through a scoreboard, plus reset and auto-poll sequences.
module tb_snes_pad_scanner;

  localparam int PADS = 2, BITS = 16, LAT = 4, HALF = 4, POLL = 200;
  localparam int SCAN_LAT = LAT + 2 * HALF * BITS + 1;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic                 auto_poll = 1'b0;
  logic                 start = 1'b0;
  logic [PADS-1:0]      serial_data = '1;
  logic                 data_latch, data_clock, update, busy;
  logic [PADS*BITS-1:0] buttons, pressed_edge;
  logic [PADS-1:0]      present;

  snes_pad_scanner #(
    .PADS(PADS), .BITS(BITS), .LATCH_CYCLES(LAT),
    .HALF_CYCLES(HALF), .POLL_CYCLES(POLL)
  ) dut (
    .clock(clock), .reset(reset), .auto_poll(auto_poll), .start(start),
    .serial_data(serial_data), .data_latch(data_latch), .data_clock(data_clock),
    .buttons(buttons), .present(present), .pressed_edge(pressed_edge),
    .update(update), .busy(busy)
  );

  always #5 clock = ~clock;

  // Pad model: parallel load while latched, shift on rising data_clock,
  // ones shifted in behind the last bit.
  logic [15:0] pad_val [PADS];
  logic [15:0] sreg [PADS] = '{16'hFFFF, 16'hFFFF};
  logic        prev_clk = 1'b1;

  always @(negedge clock) begin
    for (int p = 0; p < PADS; p++) begin
      if (data_latch) sreg[p] = pad_val[p];
      else if (data_clock && !prev_clk) sreg[p] = {1'b1, sreg[p][15:1]};
      serial_data[p] = sreg[p][0];
    end
    prev_clk = data_clock;
  end

  typedef struct {
    logic [15:0] p0;
    logic [15:0] p1;
    logic [31:0] buttons;
    logic [1:0]  present;
    logic [31:0] edges;
  } vec_t;

  typedef struct {
    logic [31:0] buttons;
    logic [1:0]  present;
    logic [31:0] edges;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One manual scan: push expectation, pulse start, watch the waveform,
  // pop and compare on update, then confirm the edge flags clear.
  task automatic run_scan(input vec_t v, input string tag);
    int   lat, latch_hi, clk_low, falls, bad_run, run, busy_n;
    logic prev_dc;
    logic [31:0] got_btn, got_edge;
    logic [1:0]  got_pres;
    exp_t e;
    lat = 0; latch_hi = 0; clk_low = 0; falls = 0; bad_run = 0; run = 0; busy_n = 0;
    prev_dc = 1'b1; got_btn = '0; got_edge = '0; got_pres = '0;
    pad_val[0] = v.p0;
    pad_val[1] = v.p1;
    sb_q.push_back('{v.buttons, v.present, v.edges});
    @(negedge clock);
    start = 1'b1;
    for (int n = 1; n <= 300 && lat == 0; n++) begin
      @(negedge clock);
      start = 1'b0;
      if (data_latch) latch_hi++;
      if (busy) busy_n++;
      if (!data_clock) begin
        clk_low++;
        run++;
        if (prev_dc) falls++;
      end else if (!prev_dc) begin
        if (run != HALF) bad_run++;
        run = 0;
      end
      prev_dc = data_clock;
      if (update) begin
        lat = n;
        got_btn = buttons; got_edge = pressed_edge; got_pres = present;
      end
    end
    check({tag, " update_seen"}, (lat != 0), 1);
    e = sb_q.pop_front();
    check({tag, " latency"}, lat, SCAN_LAT);
    check({tag, " buttons"}, got_btn, e.buttons);
    check({tag, " present"}, got_pres, e.present);
    check({tag, " pressed_edge"}, got_edge, e.edges);
    check({tag, " latch_cycles"}, latch_hi, LAT);
    check({tag, " clk_low_cycles"}, clk_low, 2 * HALF * BITS / 2);
    check({tag, " clk_pulses"}, falls, BITS);
    check({tag, " clk_pulse_width"}, bad_run, 0);
    check({tag, " busy_cycles"}, busy_n, SCAN_LAT);
    @(negedge clock);
    check({tag, " update_one_cycle"}, update, 0);
    check({tag, " edge_cleared"}, pressed_edge, 0);
    check({tag, " idle_after"}, {busy, data_clock, data_latch}, 3'b010);
    $display("scan %s: lat=%0d buttons=%h present=%b edge=%h", tag, lat, got_btn, got_pres, got_edge);
  endtask

  vec_t tbl [8];
  int   upd_t [8];
  int   n_upd;

  initial begin
    tbl[0] = '{16'h0FFE, 16'hFFFF, 32'hFFFF_0FFE, 2'b01, 32'h0000_F001};
    tbl[1] = '{16'h0FFF, 16'hFFFF, 32'hFFFF_0FFF, 2'b01, 32'h0000_0000};
    tbl[2] = '{16'h0F7F, 16'hFFFF, 32'hFFFF_0F7F, 2'b01, 32'h0000_0080};
    tbl[3] = '{16'h0F7E, 16'hFFFF, 32'hFFFF_0F7E, 2'b01, 32'h0000_0001};
    tbl[4] = '{16'h0F7E, 16'h0A5F, 32'h0A5F_0F7E, 2'b11, 32'hF5A0_0000};
    tbl[5] = '{16'h0F7E, 16'hFFFF, 32'hFFFF_0F7E, 2'b01, 32'h0000_0000};
    tbl[6] = '{16'hFFFE, 16'h1234, 32'h1234_FFFF, 2'b10, 32'hEDCB_0000};
    tbl[7] = '{16'h7FFF, 16'h1234, 32'h1234_7FFF, 2'b11, 32'h0000_8000};
    pad_val[0] = 16'hFFFF;
    pad_val[1] = 16'hFFFF;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst data_latch", data_latch, 0);
    check("rst data_clock", data_clock, 1);
    check("rst busy", busy, 0);
    check("rst update", update, 0);
    check("rst buttons", buttons, 32'hFFFF_FFFF);
    check("rst present", present, 0);
    check("rst pressed_edge", pressed_edge, 0);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("idle no auto scan", busy, 0);

    // Manual scans from the table
    for (int i = 0; i < 8; i++) run_scan(tbl[i], $sformatf("row%0d", i));

    // Reset during SHIFT_LO of bit 7, then a clean scan
    pad_val[0] = 16'h0123;
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (61) @(negedge clock);
    check("mid pre clk low", {busy, data_clock}, 2'b10);
    reset = 1'b1;
    #1;
    check("mid rst data_latch", data_latch, 0);
    check("mid rst data_clock", data_clock, 1);
    check("mid rst busy", busy, 0);
    check("mid rst buttons", buttons, 32'hFFFF_FFFF);
    check("mid rst present", present, 0);
    @(negedge clock);
    reset = 1'b0;
    run_scan(tbl[0], "after_reset");

    // Auto poll from reset with a dropped start and a mid-scan disable
    pad_val[0] = 16'h0F00;
    pad_val[1] = 16'hFFFF;
    @(negedge clock);
    reset = 1'b1;
    auto_poll = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_upd = 0;
    for (int n = 1; n <= 800; n++) begin
      @(negedge clock);
      if (n == 1) check("auto first latch", {busy, data_latch}, 2'b11);
      if (n == 50) start = 1'b1;
      if (n == 51) start = 1'b0;
      if (n == 450) auto_poll = 1'b0;
      if (n == 700) check("auto off idle", busy, 0);
      if (update) begin
        if (n_upd < 8) upd_t[n_upd] = n;
        if (n_upd == 0) begin
          check("auto buttons", buttons, 32'hFFFF_0F00);
          check("auto present", present, 2'b01);
        end
        n_upd++;
      end
    end
    check("auto update count", n_upd, 3);
    check("auto first update", upd_t[0], SCAN_LAT);
    check("auto period 1", upd_t[1] - upd_t[0], POLL);
    check("auto period 2", upd_t[2] - upd_t[1], POLL);
    $display("auto: updates=%0d at %0d %0d %0d", n_upd, upd_t[0], upd_t[1], upd_t[2]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
